// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory end of the LSQ memory interface.
//
// Committed stores enter a small in-order store buffer and drain one per
// cycle into a byte-addressed, little-endian data memory. Loads are served
// with one cycle of latency. A load is held off while its bytes overlap a
// store that has not yet drained. An accepted load takes the single memory
// port, and the drain waits for that cycle.
//
// Optional build macro: DMEM_SB_FORWARD_EN
//   When it is defined, a load whose only overlapping store is an exact lw/sw
//   address match, or an lbu that lies inside the store, is forwarded from
//   that store. Such a load does not stall and does not take the memory port.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   store_wb/addr/data  committed store push (store_sh: 0 = sw, 1 = sh)
//   sb_full, sb_empty   store buffer occupancy flags
//   load_req/addr/func3 load request (3'b010 = lw, 3'b100 = lbu)
//   load_rob_tag/pd     load identity, echoed with the response
//   load_ready          load accepted when load_req && load_ready
//   load_valid/data     load response, one-cycle pulse
//   load_rob_tag_out/pd_out  echoed identity
//   flush               kills the response of a load accepted on the same edge
module dmem_ctrl #(
   parameter int MEM_BYTES = 1024,
   parameter int SB_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        store_wb,
   input  logic [31:0] store_addr,
   input  logic [31:0] store_data,
   input  logic        store_sh,
   output logic        sb_full,
   input  logic        load_req,
   input  logic [31:0] load_addr,
   input  logic [2:0]  load_func3,
   input  logic [4:0]  load_rob_tag,
   input  logic [6:0]  load_pd,
   output logic        load_ready,
   output logic        load_valid,
   output logic [31:0] load_data,
   output logic [4:0]  load_rob_tag_out,
   output logic [6:0]  load_pd_out,
   input  logic        flush,
   output logic        sb_empty
);

   localparam int AW = $clog2(MEM_BYTES);
   localparam int PW = $clog2(SB_DEPTH);
   localparam int CW = PW + 1;

   logic [7:0]    mem     [MEM_BYTES];
   logic [AW-1:0] sb_addr [SB_DEPTH];
   logic [31:0]   sb_data [SB_DEPTH];
   logic          sb_sh   [SB_DEPTH];
   logic [PW-1:0] w_ptr, r_ptr;
   logic [CW-1:0] count;

   logic [AW-1:0] ld_idx, st_idx, ld_len, st_len;
   logic          is_lw, is_lbu;
   logic [SB_DEPTH-1:0] ovl;
   logic          ovl_in, conflict;
   logic          fwd_hit;
   logic [31:0]   fwd_data, rd_data;
   logic          load_accept, do_push, do_pop;

   // Only the low AW address bits index the memory. Upper bits wrap away.
   logic unused_addr_hi;
   assign unused_addr_hi = ^{store_addr[31:AW], load_addr[31:AW]};

   assign ld_idx = load_addr[AW-1:0];
   assign st_idx = store_addr[AW-1:0];
   assign is_lw  = (load_func3 == 3'b010);
   assign is_lbu = (load_func3 == 3'b100);
   assign ld_len = is_lw ? AW'(4) : AW'(1);
   assign st_len = store_sh ? AW'(2) : AW'(4);

   assign sb_full  = (count == CW'(SB_DEPTH));
   assign sb_empty = (count == '0);

   // Circular byte ranges overlap exactly when one range's start lies
   // inside the other range. The subtraction wraps modulo MEM_BYTES.
   function automatic logic ranges_overlap(input logic [AW-1:0] a0, input logic [AW-1:0] l0,
                                           input logic [AW-1:0] a1, input logic [AW-1:0] l1);
      logic [AW-1:0] d01, d10;
      d01 = a0 - a1;
      d10 = a1 - a0;
      return (d01 < l1) || (d10 < l0);
   endfunction

   // NOTE: every signal that always_comb writes gets a default first, so
   // that no path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      ovl = '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         logic [PW-1:0] age;
         age = PW'(i) - r_ptr;
         ovl[i] = (is_lw || is_lbu) && (CW'(age) < count) &&
                  ranges_overlap(ld_idx, ld_len, sb_addr[i], sb_sh[i] ? AW'(2) : AW'(4));
      end
      ovl_in   = (is_lw || is_lbu) && store_wb && ranges_overlap(ld_idx, ld_len, st_idx, st_len);
      conflict = (|ovl) || ovl_in;
   end

`ifdef DMEM_SB_FORWARD_EN
   logic [CW-1:0] n_ovl;
   logic [AW-1:0] f_addr, f_diff;
   logic [31:0]   f_data;
   logic          f_sh, fwd_ok;
   logic [7:0]    f_byte;

   // The store presented this cycle is the youngest of all sources. Forwarding
   // applies only when it, or one buffer entry, is the single overlap.
   always_comb begin
      n_ovl  = '0;
      f_addr = '0;
      f_data = '0;
      f_sh   = 1'b0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         if (ovl[i]) begin
            n_ovl  = n_ovl + CW'(1);
            f_addr = sb_addr[i];
            f_data = sb_data[i];
            f_sh   = sb_sh[i];
         end
      end
      if (ovl_in) begin
         n_ovl  = n_ovl + CW'(1);
         f_addr = st_idx;
         f_data = store_data;
         f_sh   = store_sh;
      end
      f_diff = ld_idx - f_addr;
      case (f_diff[1:0])
         2'd0:    f_byte = f_data[7:0];
         2'd1:    f_byte = f_data[15:8];
         2'd2:    f_byte = f_data[23:16];
         default: f_byte = f_data[31:24];
      endcase
      fwd_ok   = (n_ovl == CW'(1)) && ((is_lw && !f_sh && (f_diff == '0)) || is_lbu);
      fwd_hit  = conflict && fwd_ok;
      fwd_data = is_lw ? f_data : {24'h0, f_byte};
   end
   assign load_ready = !conflict || fwd_ok;
`else
   assign fwd_hit    = 1'b0;
   assign fwd_data   = '0;
   assign load_ready = !conflict;
`endif

   assign load_accept = load_req && load_ready;
   // A forwarded load leaves the port free, so the drain still proceeds.
   assign do_pop  = !sb_empty && !(load_accept && !fwd_hit);
   assign do_push = store_wb && !sb_full;

   always_comb begin
      rd_data = '0;
      if (is_lw)
         rd_data = {mem[ld_idx + AW'(3)], mem[ld_idx + AW'(2)],
                    mem[ld_idx + AW'(1)], mem[ld_idx]};
      else if (is_lbu)
         rd_data = {24'h0, mem[ld_idx]};
   end

   // NOTE: sequential state uses non-blocking assignments, so each register
   // samples values from before the edge regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_ptr            <= '0;
         r_ptr            <= '0;
         count            <= '0;
         load_valid       <= 1'b0;
         load_data        <= '0;
         load_rob_tag_out <= '0;
         load_pd_out      <= '0;
      end else begin
         if (do_push) w_ptr <= w_ptr + PW'(1);
         if (do_pop)  r_ptr <= r_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         load_valid <= load_accept && !flush;
         if (load_accept) begin
            load_data        <= fwd_hit ? fwd_data : rd_data;
            load_rob_tag_out <= load_rob_tag;
            load_pd_out      <= load_pd;
         end
      end
   end

   // NOTE: the buffer payload and the data memory have no reset. Valid
   // entries are tracked by the pointers, and the memory has no defined
   // power-up value. This lets the arrays map onto RAM.
   always_ff @(posedge clk) begin
      if (do_push) begin
         sb_addr[w_ptr] <= st_idx;
         sb_data[w_ptr] <= store_data;
         sb_sh[w_ptr]   <= store_sh;
      end
      if (do_pop) begin
         mem[sb_addr[r_ptr]]          <= sb_data[r_ptr][7:0];
         mem[sb_addr[r_ptr] + AW'(1)] <= sb_data[r_ptr][15:8];
         if (!sb_sh[r_ptr]) begin
            mem[sb_addr[r_ptr] + AW'(2)] <= sb_data[r_ptr][23:16];
            mem[sb_addr[r_ptr] + AW'(3)] <= sb_data[r_ptr][31:24];
         end
      end
   end

   // Retiring a store into a full buffer drops it.
   a_no_push_when_full: assert property (@(posedge clk) disable iff (reset) !(store_wb && sb_full));

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed testbench for dmem_ctrl. Expected values are worked out by hand
// from the little-endian byte layout of each store.
module tb_dmem_ctrl;

   localparam int MEM_BYTES = 1024;
   localparam int SB_DEPTH  = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        store_wb;
   logic [31:0] store_addr, store_data;
   logic        store_sh;
   logic        sb_full, sb_empty;
   logic        load_req;
   logic [31:0] load_addr;
   logic [2:0]  load_func3;
   logic [4:0]  load_rob_tag, load_rob_tag_out;
   logic [6:0]  load_pd, load_pd_out;
   logic        load_ready, load_valid;
   logic [31:0] load_data;
   logic        flush;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   dmem_ctrl #(.MEM_BYTES(MEM_BYTES), .SB_DEPTH(SB_DEPTH)) dut (
      .clk(clk), .reset(reset),
      .store_wb(store_wb), .store_addr(store_addr), .store_data(store_data),
      .store_sh(store_sh), .sb_full(sb_full),
      .load_req(load_req), .load_addr(load_addr), .load_func3(load_func3),
      .load_rob_tag(load_rob_tag), .load_pd(load_pd), .load_ready(load_ready),
      .load_valid(load_valid), .load_data(load_data),
      .load_rob_tag_out(load_rob_tag_out), .load_pd_out(load_pd_out),
      .flush(flush), .sb_empty(sb_empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic sh);
      store_wb = 1'b1; store_addr = a; store_data = d; store_sh = sh;
      step();
      store_wb = 1'b0;
      #1;
   endtask

   task automatic wait_empty(input string tag);
      int n = 0;
      while (!sb_empty && n < 20) begin
         step();
         n++;
      end
      check(tag, 32'(sb_empty), 32'd1);
   endtask

   task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] f,
                          input logic [4:0] rt, input logic [6:0] pd, input logic [31:0] exp);
      int n = 0;
      load_req = 1'b1; load_addr = a; load_func3 = f; load_rob_tag = rt; load_pd = pd;
      #1;
      while (!load_ready && n < 20) begin
         step();
         n++;
      end
      check({tag, " ready"}, 32'(load_ready), 32'd1);
      step();
      load_req = 1'b0;
      check({tag, " valid"}, 32'(load_valid), 32'd1);
      check({tag, " data"}, load_data, exp);
      check({tag, " tag"}, 32'(load_rob_tag_out), 32'(rt));
      check({tag, " pd"}, 32'(load_pd_out), 32'(pd));
      step();
      check({tag, " pulse"}, 32'(load_valid), 32'd0);
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0;
      store_wb = 1'b0; store_addr = '0; store_data = '0; store_sh = 1'b0;
      load_req = 1'b0; load_addr = '0; load_func3 = 3'b010; load_rob_tag = '0; load_pd = '0;

      // Reset state.
      step(); step();
      check("rst sb_empty", 32'(sb_empty), 32'd1);
      check("rst sb_full", 32'(sb_full), 32'd0);
      check("rst load_valid", 32'(load_valid), 32'd0);
      check("rst load_data", load_data, 32'd0);
      check("rst tag_out", 32'(load_rob_tag_out), 32'd0);
      check("rst pd_out", 32'(load_pd_out), 32'd0);
      reset = 1'b0;
      step();

      // Store one word, let it drain, then read it back.
      push_store(32'h100, 32'hDEADBEEF, 1'b0);
      check("sw100 sb_empty", 32'(sb_empty), 32'd0);
      wait_empty("sw100 drained");
      do_load("lw100", 32'h100, 3'b010, 5'd5, 7'h2A, 32'hDEADBEEF);

      // An sh writes only bytes 0x102..0x103. The upper half of store_data is ignored.
      push_store(32'h102, 32'hABCD1234, 1'b1);
`ifndef DMEM_SB_FORWARD_EN
      load_req = 1'b1; load_addr = 32'h103; load_func3 = 3'b100;
      #1;
      check("lbu103 blocked", 32'(load_ready), 32'd0);
`endif
      do_load("lbu103", 32'h103, 3'b100, 5'd6, 7'h11, 32'h00000012);
      wait_empty("sh102 drained");
      do_load("lw100 merged", 32'h100, 3'b010, 5'd7, 7'h12, 32'h1234BEEF);

      // Fill the buffer while non-overlapping loads hold the port every cycle.
      // The later stores overwrite earlier ones, so the drain order shows in memory.
      for (int i = 0; i < SB_DEPTH; i++) begin
         logic [31:0] a_tab [4];
         logic [31:0] d_tab [4];
         a_tab = '{32'h300, 32'h304, 32'h300, 32'h306};
         d_tab = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h00004444};
         store_wb = 1'b1; store_addr = a_tab[i]; store_data = d_tab[i]; store_sh = (i == 3);
         load_req = 1'b1; load_addr = 32'h100; load_func3 = 3'b010;
         load_rob_tag = 5'(i); load_pd = 7'(i);
         #1;
         check($sformatf("fill%0d ready", i), 32'(load_ready), 32'd1);
         step();
         check($sformatf("fill%0d data", i), load_data, 32'h1234BEEF);
      end
      store_wb = 1'b0;
      check("fill sb_full", 32'(sb_full), 32'd1);
      step();
      check("full held under load", 32'(sb_full), 32'd1);
      load_req = 1'b0;
      step(); step(); step();
      check("drain 3 not empty", 32'(sb_empty), 32'd0);
      step();
      check("drain 4 empty", 32'(sb_empty), 32'd1);
      do_load("lw300", 32'h300, 3'b010, 5'd8, 7'h30, 32'h33333333);
      do_load("lw304", 32'h304, 3'b010, 5'd9, 7'h31, 32'h44442222);

      // A store and a load to the same word in the same cycle.
      store_wb = 1'b1; store_addr = 32'h200; store_data = 32'hCAFEF00D; store_sh = 1'b0;
      load_req = 1'b1; load_addr = 32'h200; load_func3 = 3'b010; load_rob_tag = 5'd10; load_pd = 7'h40;
      #1;
`ifdef DMEM_SB_FORWARD_EN
      check("raw200 fwd ready", 32'(load_ready), 32'd1);
      step();
      store_wb = 1'b0; load_req = 1'b0;
      check("raw200 valid", 32'(load_valid), 32'd1);
      check("raw200 data", load_data, 32'hCAFEF00D);
`else
      check("raw200 ready c0", 32'(load_ready), 32'd0);
      step();
      store_wb = 1'b0;
      #1;
      check("raw200 ready c1", 32'(load_ready), 32'd0);
      step();
      check("raw200 ready after drain", 32'(load_ready), 32'd1);
      step();
      load_req = 1'b0;
      check("raw200 valid", 32'(load_valid), 32'd1);
      check("raw200 data", load_data, 32'hCAFEF00D);
      check("raw200 tag", 32'(load_rob_tag_out), 32'd10);
`endif
      wait_empty("raw200 drained");

      // Flush kills the load response. A store pushed in that cycle still lands in memory.
      store_wb = 1'b1; store_addr = 32'h208; store_data = 32'h5A5A5A5A; store_sh = 1'b0;
      load_req = 1'b1; load_addr = 32'h100; load_func3 = 3'b010; flush = 1'b1;
      #1;
      check("flush ready", 32'(load_ready), 32'd1);
      step();
      store_wb = 1'b0; load_req = 1'b0; flush = 1'b0;
      check("flush no valid", 32'(load_valid), 32'd0);
      wait_empty("flush store drained");
      do_load("lw208", 32'h208, 3'b010, 5'd11, 7'h50, 32'h5A5A5A5A);

      // The word access wraps around the top of memory.
      push_store(32'(MEM_BYTES - 2), 32'h00002211, 1'b1);
      push_store(32'h0, 32'h00004433, 1'b1);
      wait_empty("wrap drained");
      do_load("lw wrap", 32'(MEM_BYTES - 2), 3'b010, 5'd12, 7'h60, 32'h44332211);
      do_load("lbu top", 32'(MEM_BYTES - 1), 3'b100, 5'd13, 7'h61, 32'h00000022);

      // An unsupported func3 is accepted and returns zero.
      do_load("bad func3", 32'h100, 3'b000, 5'd14, 7'h62, 32'h00000000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Stops a hung run with a visible failure.
   initial begin
      #200000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory end of the LSQ memory interface.
- Accepts committed stores (sw/sh) from LSQ retirement into a small in-order store buffer, and drains them one per cycle into a byte-addressed data memory.
- Services LSQ load requests (lw/lbu) with 1-cycle read latency.
- Blocks loads that overlap a not-yet-drained store.

Parameters:
- MEM_BYTES, 1024, data memory size in bytes; power of two; address index = addr[$clog2(MEM_BYTES)-1:0], wraps modulo MEM_BYTES.
- SB_DEPTH, 4, committed-store buffer entries; power of two, >=2.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- store_wb  input  1  committed store valid (one-cycle pulse per store)
- store_addr  input  32  store byte address
- store_data  input  32  store data; sh uses [15:0]
- store_sh  input  1  0 = sw (4 bytes), 1 = sh (2 bytes)
- sb_full  output  1  store buffer full; LSQ/ROB must not retire a store while high
- load_req  input  1  load request valid
- load_addr  input  32  load byte address
- load_func3  input  3  3'b010 = lw, 3'b100 = lbu
- load_rob_tag  input  5  ROB tag of load
- load_pd  input  7  destination physical register
- load_ready  output  1  load accepted this cycle when load_req && load_ready
- load_valid  output  1  load response valid (one-cycle pulse)
- load_data  output  32  load result; lbu zero-extended
- load_rob_tag_out  output  5  echoed ROB tag
- load_pd_out  output  7  echoed pd
- flush  input  1  mispredict; kills in-flight load response
- sb_empty  output  1  store buffer empty (for drain/fence checks)

Behaviour:
- Reset: sb pointers/count = 0; sb_full = 0; sb_empty = 1; load_valid = 0; load_data, load_rob_tag_out, load_pd_out = 0. Memory contents are not reset.
- Memory is little-endian and byte-granular. Byte k of a word access is at index (addr+k) mod MEM_BYTES, so misaligned and wrapping accesses are legal.
- Store buffer is a circular FIFO with count 0..SB_DEPTH.
  - sb_full = (count == SB_DEPTH); sb_empty = (count == 0); both combinational from registered count.
  - Push: store_wb at edge N writes the entry at w_ptr.
  - Push while full (including a same-cycle pop) is illegal: the entry is dropped and the simulation assertion fires.
- Drain:
  - Each edge where the buffer is non-empty and no load is accepted that cycle, the head entry is written to memory (4 bytes for sw, 2 for sh) and popped.
  - Earliest memory update for a store pushed at edge N is edge N+1.
  - Push and pop in the same cycle leave count unchanged; pointers wrap at SB_DEPTH-1 -> 0.
- Single memory port: an accepted load wins the port and the drain stalls for that cycle.
  - A drain deferred by loads is not starvation-protected.
  - The LSQ issues at most one load per cycle.
- Conflict check (combinational):
  - A load conflicts if its byte range [addr, addr+L-1] (L = 4 lw, 1 lbu) overlaps the byte range of any valid sb entry, or of a store presented on store_wb in the same cycle.
  - Ranges compare on indices modulo MEM_BYTES.
  - load_ready = !conflict.
  - While a conflict exists, the drain proceeds every cycle, so the conflict clears in at most SB_DEPTH+1 cycles.
- Load latency: a load accepted at edge N raises load_valid for exactly one cycle after edge N, with data from memory as of before edge N. Tag and pd are echoed.
- Unsupported load_func3: the load is accepted and returns load_data = 0.
- flush:
  - flush high at edge N forces load_valid = 0 after edge N, discarding a load accepted at edge N.
  - The store buffer is never flushed, because its entries are committed.
  - flush does not affect load_ready.
- Simultaneous store_wb, load_req and non-empty buffer: the push occurs; the load is accepted only if it does not conflict, in which case the pop is skipped.

Optional Feature:
DMEM_SB_FORWARD_EN
- Defined:
  - A load whose only overlapping entry is the youngest overlapping store is forwarded from that store instead of stalling, when it is one of:
    - lw with addr equal to an sw address.
    - lbu fully inside an sw or sh. The byte is selected by (load_addr - store_addr) mod 4, zero-extended.
  - Such loads are accepted with the same 1-cycle latency and do not take the memory port, so the drain proceeds that cycle.
  - Partial overlaps still stall.
- Undefined: every overlap stalls, as specified above.

Test Plan:
- Reset, then sw 0x100 = 0xDEADBEEF; after the buffer drains, lw 0x100 -> load_valid one cycle after acceptance, load_data = 0xDEADBEEF, tag/pd echoed.
- sh 0x102 = 0x1234 over that word, then lbu 0x103 -> 0x00000012; lw 0x100 -> 0x1234BEEF.
- Push 4 stores while loads to non-overlapping addresses are issued every cycle -> sb_full = 1, no drain while loads are accepted; stop loads -> sb_empty within 4 cycles, and memory holds all 4 stores in order.
- sw 0x200 = 0xCAFEF00D, with lw 0x200 issued in the same cycle:
  - Forward undefined: load_ready = 0 until the drain, then returns 0xCAFEF00D.
  - Forward defined: accepted immediately, returns 0xCAFEF00D.
- Load accepted with flush asserted on the same edge -> no load_valid; a store pushed in that cycle is still written.
- lw at MEM_BYTES-2 after bytes 0x11,0x22 at MEM_BYTES-2/-1 and 0x33,0x44 at 0/1 -> 0x44332211.
